// File: rtl/pito_prog_loader_if.sv
// Loader-facing bundle: host byte stream in, imem write port and core control out.
// The host/bench drives the master side; pito_prog_loader implements the slave side.
interface pito_prog_loader_if #(
    parameter int IMEM_ADDR_W = 10
) ();
    logic                   start;
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic                   imem_we;
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [31:0]            imem_wdata;
    logic                   core_rst;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err
    );
endinterface

// File: rtl/pito_prog_loader.sv
// Streams a little-endian program image (word count, payload words) into rv32 imem,
// holding the core in reset until the load completes. PITO_LOADER_CHECKSUM_EN adds a trailing sum check.
module pito_prog_loader #(
    parameter int IMEM_ADDR_W = 10
) (
    input logic               clk,
    input logic               rst,
    pito_prog_loader_if.slave bus
);
    localparam int          IDX_W    = IMEM_ADDR_W + 1;
    localparam logic [31:0] CAPACITY = 32'(1) << IMEM_ADDR_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        PAYLOAD = 3'd2,
        FLUSH   = 3'd3,
`ifdef PITO_LOADER_CHECKSUM_EN
        CKSUM   = 3'd4,
`endif
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             byte_cnt_q;
    logic [23:0]            shreg_q;
    logic [IDX_W-1:0]       n_words_q;
    logic [IDX_W-1:0]       word_idx_q;
    logic                   imem_we_q;
    logic [IMEM_ADDR_W-1:0] imem_addr_q;
    logic [31:0]            imem_wdata_q;
`ifdef PITO_LOADER_CHECKSUM_EN
    logic [31:0]            sum_q;
`endif

    logic        rx_ready;
    logic        accept;
    logic        word_done;
    logic        last_word;
    logic        hdr_bad;
    logic        restart;
    logic [31:0] rx_word;

`ifdef PITO_LOADER_CHECKSUM_EN
    assign rx_ready = state_q inside {HDR, PAYLOAD, CKSUM};
`else
    assign rx_ready = state_q inside {HDR, PAYLOAD};
`endif

    // The fourth byte completes a word straight off the bus, so no extra cycle is spent assembling it.
    assign accept    = bus.rx_valid && rx_ready;
    assign word_done = accept && (byte_cnt_q == 2'd3);
    assign rx_word   = {bus.rx_data, shreg_q};
    assign last_word = (word_idx_q == n_words_q - IDX_W'(1));
    assign hdr_bad   = (rx_word == 32'd0) || (rx_word > CAPACITY);
    assign restart   = bus.start && (state_q inside {IDLE, DONE, ERR});

    always_comb begin
        // NOTE: default assigned first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = HDR;
            HDR:     if (word_done) state_d = hdr_bad ? ERR : PAYLOAD;
            PAYLOAD: if (word_done && last_word) begin
`ifdef PITO_LOADER_CHECKSUM_EN
                state_d = CKSUM;
`else
                state_d = FLUSH;
`endif
            end
            FLUSH:   state_d = DONE;
`ifdef PITO_LOADER_CHECKSUM_EN
            CKSUM:   if (word_done) state_d = (rx_word == sum_q) ? DONE : ERR;
`endif
            DONE:    if (bus.start) state_d = HDR;
            ERR:     if (bus.start) state_d = HDR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            shreg_q      <= '0;
            n_words_q    <= '0;
            word_idx_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
`ifdef PITO_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            state_q   <= state_d;
            imem_we_q <= 1'b0;
            if (restart) begin
                byte_cnt_q <= '0;
                word_idx_q <= '0;
`ifdef PITO_LOADER_CHECKSUM_EN
                sum_q      <= '0;
`endif
            end else if (accept) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                shreg_q    <= rx_word[31:8];
                if (word_done && state_q == HDR) begin
                    n_words_q <= rx_word[IDX_W-1:0];
                end
                if (word_done && state_q == PAYLOAD) begin
                    imem_we_q    <= 1'b1;
                    imem_addr_q  <= word_idx_q[IMEM_ADDR_W-1:0];
                    imem_wdata_q <= rx_word;
                    word_idx_q   <= word_idx_q + IDX_W'(1);
`ifdef PITO_LOADER_CHECKSUM_EN
                    sum_q        <= sum_q + rx_word;
`endif
                end
            end
        end
    end

    assign bus.rx_ready   = rx_ready;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.core_rst   = (state_q != DONE);
    assign bus.busy       = rx_ready || (state_q == FLUSH);
    assign bus.done       = (state_q == DONE);
    assign bus.err        = (state_q == ERR);
endmodule

// File: tb/tb_pito_prog_loader.sv
// Self-checking bench for pito_prog_loader: random images and gaps, compared against a stream-level model.
// Define PITO_LOADER_CHECKSUM_EN for both RTL and bench to exercise the checksum trailer.
module tb_pito_prog_loader;
    localparam int AW  = 10;
    localparam int CAP = 1 << AW;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    wr_t  wlog[$];
    int   fall_cyc = -1;
    bit   prev_crst = 1'b1;
    bit   crst_low_seen = 1'b0;

    pito_prog_loader_if #(.IMEM_ADDR_W(AW)) bus ();
    pito_prog_loader #(.IMEM_ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log every imem write and the cycle core_rst falls.
    always @(negedge clk) begin
        if (bus.imem_we) wlog.push_back({32'(bus.imem_addr), bus.imem_wdata, 32'(cyc)});
        if (prev_crst && !bus.core_rst) fall_cyc <= cyc;
        if (!bus.core_rst) crst_low_seen <= 1'b1;
        prev_crst <= bus.core_rst;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    function automatic bq_t le_append(bq_t s, logic [31:0] w);
        for (int b = 0; b < 4; b++) s.push_back(w[8*b +: 8]);
        return s;
    endfunction

    // Stream = word count, payload words, and (with the feature) sum + ck_delta.
    function automatic bq_t make_stream(wq_t words, logic [31:0] ck_delta);
        bq_t s = {};
        logic [31:0] sum = 32'd0;
        s = le_append(s, 32'(words.size()));
        foreach (words[i]) begin
            s = le_append(s, words[i]);
            sum = sum + words[i];
        end
`ifdef PITO_LOADER_CHECKSUM_EN
        s = le_append(s, sum + ck_delta);
`else
        if (ck_delta != 32'd0 && sum == 32'd0) s = s;
`endif
        return s;
    endfunction

    // Word i goes to address i, visible in the cycle right after its last byte (stream byte 4+4i+3).
    task automatic model_writes(input wq_t words, input int acc[$], output wr_t exp[$]);
        exp = {};
        foreach (words[i]) begin
            int k = 4 + 4 * i + 3;
            exp.push_back({32'(i), words[i], (k < acc.size()) ? 32'(acc[k]) : 32'hffff_ffff});
        end
    endtask

    task automatic send_stream(input bq_t bytes, input bit gaps, output int acc[$]);
        int i = 0;
        int stall = 0;
        acc = {};
        while (i < bytes.size()) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.rx_valid = 1'b0;
            end else begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = bytes[i];
                if (bus.rx_ready) begin
                    acc.push_back(cyc + 1);
                    i++;
                    stall = 0;
                end else if (++stall > 20) begin
                    tests++;
                    fails++;
                    $display("FAIL rx_ready_timeout: byte %0d of %0d not accepted, rx_ready=%0b want 1", i, bytes.size(), bus.rx_ready);
                    i = bytes.size();
                end
            end
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!(bus.done || bus.err) && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!(bus.done || bus.err)) begin
            fails++;
            $display("FAIL %s_end_timeout: done=%0b err=%0b want one of them high", name, bus.done, bus.err);
        end
        #1;
    endtask

    task automatic test_reset();
        logic [45:0] got;
        logic [45:0] want;
        bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        got  = {bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.core_rst, bus.busy, bus.done, bus.err};
        want = {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL reset_values: got %h want %h", got, want);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        wq_t w = '{32'h0000_0013, 32'h0010_0093};
        bq_t s;
        int  acc[$];
        wr_t exp[$];
        int  want_fall;
        pulse_start();
        wlog = {};
        fall_cyc = -1;
        s = make_stream(w, 32'd0);
        send_stream(s, 1'b0, acc);
        wait_end("basic");
        model_writes(w, acc, exp);
        tests++;
        if (wlog.size() !== exp.size()) begin
            fails++;
            $display("FAIL basic_wcount: got %0d want %0d", wlog.size(), exp.size());
        end
        foreach (exp[i]) if (i < wlog.size()) begin
            tests++;
            if (wlog[i] !== exp[i]) begin
                fails++;
                $display("FAIL basic_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                         wlog[i].addr, wlog[i].data, wlog[i].cyc, exp[i].addr, exp[i].data, exp[i].cyc);
            end
        end
`ifdef PITO_LOADER_CHECKSUM_EN
        want_fall = acc[acc.size() - 1];
`else
        want_fall = int'(exp[exp.size() - 1].cyc) + 1;
`endif
        tests++;
        if (fall_cyc !== want_fall) begin
            fails++;
            $display("FAIL basic_core_rst_fall: got cyc %0d want %0d", fall_cyc, want_fall);
        end
        tests++;
        if ({bus.done, bus.err, bus.busy, bus.core_rst} !== 4'b1000) begin
            fails++;
            $display("FAIL basic_status: got done/err/busy/core_rst=%b want 1000", {bus.done, bus.err, bus.busy, bus.core_rst});
        end
    endtask

    task automatic test_reload();
        wq_t w = {};
        bq_t s;
        int  acc1[$];
        int  acc2[$];
        int  acc[$];
        wr_t exp[$];
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        tests++;
        if ({bus.core_rst, bus.busy, bus.done} !== 3'b110) begin
            fails++;
            $display("FAIL reload_restart: got core_rst/busy/done=%b want 110", {bus.core_rst, bus.busy, bus.done});
        end
        wlog = {};
        s = make_stream(w, 32'd0);
        send_stream(s[0:5], 1'b1, acc1);
        pulse_start();
        tests++;
        if ({bus.busy, bus.err, bus.done} !== 3'b100) begin
            fails++;
            $display("FAIL ignored_start: got busy/err/done=%b want 100", {bus.busy, bus.err, bus.done});
        end
        send_stream(s[6:$], 1'b1, acc2);
        acc = {acc1, acc2};
        wait_end("reload");
        model_writes(w, acc, exp);
        tests++;
        if (wlog.size() !== exp.size()) begin
            fails++;
            $display("FAIL reload_wcount: got %0d want %0d", wlog.size(), exp.size());
        end
        foreach (exp[i]) if (i < wlog.size()) begin
            tests++;
            if (wlog[i] !== exp[i]) begin
                fails++;
                $display("FAIL reload_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                         wlog[i].addr, wlog[i].data, wlog[i].cyc, exp[i].addr, exp[i].data, exp[i].cyc);
            end
        end
        tests++;
        if (bus.done !== 1'b1) begin
            fails++;
            $display("FAIL reload_done: got %0b want 1", bus.done);
        end
    endtask

    task automatic test_bad_header();
        bq_t s0 = '{8'h00, 8'h00, 8'h00, 8'h00};
        bq_t s1 = '{8'h01, 8'h04, 8'h00, 8'h00};
        int  acc[$];
        pulse_start();
        crst_low_seen = 1'b0;
        wlog = {};
        send_stream(s0, 1'b0, acc);
        wait_end("hdr_zero");
        tests++;
        if ({bus.err, bus.done, bus.core_rst} !== 3'b101 || wlog.size() != 0) begin
            fails++;
            $display("FAIL hdr_zero: got err/done/core_rst=%b writes=%0d want 101 writes=0",
                     {bus.err, bus.done, bus.core_rst}, wlog.size());
        end
        pulse_start();
        tests++;
        if ({bus.err, bus.core_rst, bus.busy} !== 3'b011) begin
            fails++;
            $display("FAIL err_restart: got err/core_rst/busy=%b want 011", {bus.err, bus.core_rst, bus.busy});
        end
        send_stream(s1, 1'b0, acc);
        wait_end("hdr_big");
        tests++;
        if ({bus.err, bus.done} !== 2'b10 || wlog.size() != 0) begin
            fails++;
            $display("FAIL hdr_over_capacity: got err/done=%b writes=%0d want 10 writes=0", {bus.err, bus.done}, wlog.size());
        end
        tests++;
        if (crst_low_seen !== 1'b0) begin
            fails++;
            $display("FAIL bad_hdr_core_rst: got core_rst low during bad loads, want held high");
        end
    endtask

    task automatic test_full();
        wq_t w = {};
        bq_t s;
        int  acc[$];
        wr_t exp[$];
        for (int i = 0; i < CAP; i++) w.push_back($urandom);
        pulse_start();
        wlog = {};
        s = make_stream(w, 32'd0);
        send_stream(s, 1'b1, acc);
        wait_end("full");
        model_writes(w, acc, exp);
        tests++;
        if (wlog.size() !== exp.size()) begin
            fails++;
            $display("FAIL full_wcount: got %0d want %0d", wlog.size(), exp.size());
        end
        foreach (exp[i]) if (i < wlog.size()) begin
            tests++;
            if (wlog[i] !== exp[i]) begin
                fails++;
                $display("FAIL full_write[%0d]: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", i,
                         wlog[i].addr, wlog[i].data, wlog[i].cyc, exp[i].addr, exp[i].data, exp[i].cyc);
            end
        end
        tests++;
        if ({bus.done, bus.err} !== 2'b10) begin
            fails++;
            $display("FAIL full_done: got done/err=%b want 10", {bus.done, bus.err});
        end
    endtask

    task automatic test_reset_mid();
        wq_t w = {};
        wq_t w1 = {};
        bq_t s;
        int  acc[$];
        wr_t exp[$];
        logic [45:0] got;
        logic [45:0] want;
        for (int i = 0; i < 3; i++) w.push_back($urandom | 32'h1);
        w1.push_back($urandom);
        pulse_start();
        s = make_stream(w, 32'd0);
        send_stream(s[0:8], 1'b0, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got  = {bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.core_rst, bus.busy, bus.done, bus.err};
        want = {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL midload_reset_values: got %h want %h", got, want);
        end
        rst = 1'b0;
        pulse_start();
        wlog = {};
        s = make_stream(w1, 32'd0);
        send_stream(s, 1'b1, acc);
        wait_end("after_reset");
        model_writes(w1, acc, exp);
        tests++;
        if (wlog.size() !== 1 || wlog[0] !== exp[0]) begin
            fails++;
            $display("FAIL after_reset_write: got n=%0d first=%h want n=1 first=%h", wlog.size(),
                     (wlog.size() > 0) ? wlog[0] : 96'h0, exp[0]);
        end
        tests++;
        if (bus.done !== 1'b1) begin
            fails++;
            $display("FAIL after_reset_done: got %0b want 1", bus.done);
        end
    endtask

`ifdef PITO_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        wq_t w = '{32'h0000_0013, 32'h0010_0093};
        bq_t s;
        int  acc[$];
        logic [31:0] c_good;
        pulse_start();
        s = make_stream(w, 32'd0);
        c_good = {s[15], s[14], s[13], s[12]};
        tests++;
        if (c_good !== 32'h0010_00A6) begin
            fails++;
            $display("FAIL cksum_stream: got C=%h want 001000a6", c_good);
        end
        send_stream(s, 1'b0, acc);
        wait_end("cksum_good");
        tests++;
        if ({bus.done, bus.err, bus.core_rst} !== 3'b100) begin
            fails++;
            $display("FAIL cksum_good: got done/err/core_rst=%b want 100", {bus.done, bus.err, bus.core_rst});
        end
        pulse_start();
        crst_low_seen = 1'b0;
        wlog = {};
        s = make_stream(w, 32'd1);
        send_stream(s, 1'b1, acc);
        wait_end("cksum_bad");
        tests++;
        if ({bus.done, bus.err, bus.core_rst} !== 3'b011 || crst_low_seen !== 1'b0 || wlog.size() != 2) begin
            fails++;
            $display("FAIL cksum_bad: got done/err/core_rst=%b low_seen=%0b writes=%0d want 011 0 2",
                     {bus.done, bus.err, bus.core_rst}, crst_low_seen, wlog.size());
        end
    endtask
`endif

    initial begin
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst          = 1'b1;
        test_reset();
        test_basic();
        test_reload();
        test_bad_header();
        test_full();
        test_reset_mid();
`ifdef PITO_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
